// File: rtl/ssb_pkg.sv
// Shared types and default address map for the system-bus arbiter.
package ssb_pkg;

    localparam int unsigned N_HOSTS = 3;

    typedef enum logic [1:0] {
        HOST_DBG = 2'd0,
        HOST_INS = 2'd1,
        HOST_DAT = 2'd2
    } host_e;

    typedef enum logic [1:0] {
        DEV_NONE = 2'd0,
        DEV_SRAM = 2'd1,
        DEV_DMEM = 2'd2
    } dev_e;

    localparam logic [31:0] MEM_START_DEF    = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK_DEF     = 32'h0000_FFFF;
    localparam logic [31:0] DBG_START_DEF    = 32'h1A11_0000;
    localparam logic [31:0] DBG_MASK_DEF     = 32'h0000_FFFF;
    localparam int unsigned MAX_DBG_HOLD_DEF = 8;

    function automatic logic in_region(logic [31:0] addr, logic [31:0] start, logic [31:0] mask);
        return (addr & ~mask) == start;
    endfunction

endpackage

// File: rtl/ssb_arbiter_if.sv
// Host-side request/response bus and the shared device-side bus of the arbiter.
interface ssb_host_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

interface ssb_dev_if;
    logic        sram_req;
    logic        dmem_req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] sram_rdata;
    logic [31:0] dmem_rdata;

    modport master (output sram_req, dmem_req, addr, we, be, wdata, input sram_rdata, dmem_rdata);
    modport slave  (input sram_req, dmem_req, addr, we, be, wdata, output sram_rdata, dmem_rdata);
endinterface

// File: rtl/ssb_rr_arb2.sv
// Two-requester round-robin: the registered pointer favours whichever side was not granted last.
module ssb_rr_arb2 (
    input  logic       clk_sys,
    input  logic       rst_sys_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_prefer_1;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_prefer_1 ? 2'b10 : 2'b01;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_prefer_1 <= 1'b0;
        end else if (o_gnt[0]) begin
            r_prefer_1 <= 1'b1;
        end else if (o_gnt[1]) begin
            r_prefer_1 <= 1'b0;
        end
    end

endmodule

// File: rtl/ssb_arbiter.sv
// Shared system-bus arbiter: debug SBA, Ibex instr and Ibex data onto SRAM / debug memory,
// with a bounded debug priority and a one-cycle response stage routed back to the owner.
module ssb_arbiter
    import ssb_pkg::*;
#(
    parameter logic [31:0] MemStart   = MEM_START_DEF,
    parameter logic [31:0] MemMask    = MEM_MASK_DEF,
    parameter logic [31:0] DebugStart = DBG_START_DEF,
    parameter logic [31:0] DebugMask  = DBG_MASK_DEF,
    parameter int unsigned MaxDbgHold = MAX_DBG_HOLD_DEF
) (
    input  logic      clk_sys,
    input  logic      rst_sys_n,
    ssb_host_if.slave dbg_bus,
    ssb_host_if.slave ins_bus,
    ssb_host_if.slave dat_bus,
    ssb_dev_if.master dev_bus
);

    localparam logic [7:0] HOLD_MAX = 8'(MaxDbgHold);
    localparam logic REGIONS_OVERLAP =
        ((MemStart ^ DebugStart) & ~(MemMask | DebugMask)) == 32'h0;

    logic [7:0]         r_hold;
    logic [N_HOSTS-1:0] r_rsp_host;
    dev_e               r_rsp_dev;

    logic               w_core_pend;
    logic               w_dbg_yield;
    logic               w_dbg_win;
    logic [1:0]         w_core_req;
    logic [1:0]         w_core_gnt;
    logic [N_HOSTS-1:0] w_gnt;
    logic [31:0]        w_addr;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    dev_e               w_dev;
    logic [31:0]        w_rsp_data;
    logic               w_rsp_err;
    logic               w_unused_ins;

    // The instruction port is read-only; its write payload is never forwarded.
    assign w_unused_ins = ^{ins_bus.we, ins_bus.be, ins_bus.wdata};

    // Grants are held off while reset is asserted so every output reads zero.
    assign w_core_req  = {dat_bus.req, ins_bus.req} & {2{rst_sys_n}};
    assign w_core_pend = |w_core_req;
    assign w_dbg_yield = (r_hold == HOLD_MAX) && w_core_pend;
    assign w_dbg_win   = rst_sys_n && dbg_bus.req && !w_dbg_yield;

    ssb_rr_arb2 u_rr_core (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .i_en      (!w_dbg_win),
        .i_req     (w_core_req),
        .o_gnt     (w_core_gnt)
    );

    assign w_gnt[HOST_DBG] = w_dbg_win;
    assign w_gnt[HOST_INS] = w_core_gnt[0];
    assign w_gnt[HOST_DAT] = w_core_gnt[1];

    assign dbg_bus.gnt = w_gnt[HOST_DBG];
    assign ins_bus.gnt = w_gnt[HOST_INS];
    assign dat_bus.gnt = w_gnt[HOST_DAT];

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        if (w_gnt[HOST_DBG]) begin
            w_addr  = dbg_bus.addr;
            w_we    = dbg_bus.we;
            w_be    = dbg_bus.be;
            w_wdata = dbg_bus.wdata;
        end else if (w_gnt[HOST_INS]) begin
            w_addr  = ins_bus.addr;
            w_be    = 4'hF;
        end else if (w_gnt[HOST_DAT]) begin
            w_addr  = dat_bus.addr;
            w_we    = dat_bus.we;
            w_be    = dat_bus.be;
            w_wdata = dat_bus.wdata;
        end
    end

    // SRAM is checked first so it wins if the regions are ever misconfigured to overlap.
    always_comb begin
        w_dev = DEV_NONE;
        if (|w_gnt) begin
            if (in_region(w_addr, MemStart, MemMask)) begin
                w_dev = DEV_SRAM;
            end else if (in_region(w_addr, DebugStart, DebugMask)) begin
                w_dev = DEV_DMEM;
            end
        end
    end

    assign dev_bus.sram_req = (w_dev == DEV_SRAM);
    assign dev_bus.dmem_req = (w_dev == DEV_DMEM);
    assign dev_bus.addr     = w_addr;
    assign dev_bus.we       = w_we;
    assign dev_bus.be       = w_be;
    assign dev_bus.wdata    = w_wdata;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_hold     <= '0;
            r_rsp_host <= '0;
            r_rsp_dev  <= DEV_NONE;
        end else begin
            r_rsp_host <= w_gnt;
            r_rsp_dev  <= w_dev;
            if (w_dbg_win && w_core_pend) begin
                if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + 8'd1;
                end
            end else begin
                r_hold <= '0;
            end
        end
    end

    always_comb begin
        w_rsp_data = '0;
        case (r_rsp_dev)
            DEV_SRAM: w_rsp_data = dev_bus.sram_rdata;
            DEV_DMEM: w_rsp_data = dev_bus.dmem_rdata;
            default:  w_rsp_data = '0;
        endcase
    end

    assign w_rsp_err = (r_rsp_dev == DEV_NONE);

    assign dbg_bus.rvalid = r_rsp_host[HOST_DBG];
    assign ins_bus.rvalid = r_rsp_host[HOST_INS];
    assign dat_bus.rvalid = r_rsp_host[HOST_DAT];
    assign dbg_bus.err    = r_rsp_host[HOST_DBG] && w_rsp_err;
    assign ins_bus.err    = r_rsp_host[HOST_INS] && w_rsp_err;
    assign dat_bus.err    = r_rsp_host[HOST_DAT] && w_rsp_err;
    assign dbg_bus.rdata  = r_rsp_host[HOST_DBG] ? w_rsp_data : 32'h0;
    assign ins_bus.rdata  = r_rsp_host[HOST_INS] ? w_rsp_data : 32'h0;
    assign dat_bus.rdata  = r_rsp_host[HOST_DAT] ? w_rsp_data : 32'h0;

    a_no_overlap: assert property (@(posedge clk_sys) !REGIONS_OVERLAP);
    a_hold_range: assert property (@(posedge clk_sys) (MaxDbgHold >= 1) && (MaxDbgHold <= 255));
    a_gnt_onehot: assert property (@(posedge clk_sys) disable iff (!rst_sys_n) $onehot0(w_gnt));
    a_rvalid_onehot: assert property (@(posedge clk_sys) disable iff (!rst_sys_n) $onehot0(r_rsp_host));
    a_rsp_follows: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
        (|w_gnt) |=> (|r_rsp_host));
    a_no_spurious: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
        !(|w_gnt) |=> !(|r_rsp_host));

endmodule

// File: doc/ssb_arbiter.md
# ssb_arbiter

Arbiter and address decoder for the shared system bus on clk_sys. It shares one single-port bus between three hosts: the debug-module SBA port, the Ibex instruction port and the Ibex data port. It decodes the granted address to the SRAM or debug-memory device and routes each one-cycle-latency response, with error flag, back to the host that issued it. It replaces the fixed-priority combinational mux at the top level, so the debug host can no longer starve the core and the core can no longer starve itself.

## Interface
Parameters:
- MemStart, 32'h0000_0000, SRAM region base.
- MemMask, 32'h0000_FFFF, SRAM region size-1 (power-of-two region).
- DebugStart, 32'h1A11_0000, debug-memory region base.
- DebugMask, 32'h0000_FFFF, debug-memory region size-1.
- MaxDbgHold, 8, max consecutive cycles the debug host may win while a core request waits (1..255).

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset: rst_sys_n, asynchronous, active-low; clock clk_sys.
- {dbg,ins,dat}_req_i  in  1  host request, held until gnt.
- {dbg,ins,dat}_gnt_o  out  1  grant, same cycle as accepted req.
- {dbg,ins,dat}_addr_i  in  32  byte address.
- {dbg,dat}_we_i  in  1  write enable (ins is read-only).
- {dbg,dat}_be_i  in  4  byte enables.
- {dbg,dat}_wdata_i  in  32  write data.
- {dbg,ins,dat}_rvalid_o  out  1  response valid.
- {dbg,ins,dat}_err_o  out  1  response error (unmapped address), valid with rvalid.
- {dbg,ins,dat}_rdata_o  out  32  read data, valid with rvalid.
- sram_req_o, dmem_req_o  out  1  device select strobes.
- dev_addr_o  out  32; dev_we_o  out  1; dev_be_o  out  4; dev_wdata_o  out  32  shared request payload.
- sram_rdata_i, dmem_rdata_i  in  32  device read data, 1 cycle after the device req.

## Operation
- At most one grant per cycle. The grant is combinational from the req inputs and the registered arbitration state. Payload muxes follow the winner. For ins, we=0 and be=4'hF.
- Priority: dbg wins over core hosts. Exception: hold counter == MaxDbgHold and a core req is pending. Then dbg loses for one cycle and the counter clears.
- Hold counter: increments when dbg is granted while ins or dat req is high. Clears when no core req is waiting or when a core host is granted. It saturates at MaxDbgHold.
- ins versus dat: 2-way round robin. The pointer favours the host not granted last. The pointer updates only when one of them is granted. Reset favours ins.
- Decode on the granted address: (addr & ~MemMask)==MemStart gives sram_req_o. (addr & ~DebugMask)==DebugStart gives dmem_req_o. No match gives no device strobe, but the request is still granted.
- Response stage registers: one-hot host id (rsp_host_q) and device id (rsp_dev_q ∈ NONE/SRAM/DMEM). In the next cycle, only the owning host sees rvalid=1.
  - rdata comes from the selected device.
  - For NONE: err=1, rdata=32'h0.
  - Non-owning hosts see rdata=0.
- Writes also produce an rvalid (err as for reads).
- No req: all gnt=0, device strobes=0, payload outputs=0.

## Timing
- Reset values: all gnt/rvalid/err/strobes 0, rdata 0, payload 0, hold counter 0, RR pointer to ins, rsp_host_q=0, rsp_dev_q=NONE.
- gnt at cycle N gives rvalid exactly at N+1. Back-to-back grants to any mix of hosts are allowed every cycle (fully pipelined, depth 1).
- Simultaneous dbg+ins+dat: dbg is granted, subject to the hold rule. ins and dat wait with their req held, and the arbiter must tolerate this.
- Simultaneous ins+dat, no dbg: the RR pointer decides. Sustained contention alternates ins, dat, ins, …
- Reset asserted mid-transaction: the pending response is dropped and no rvalid follows reset release.
- Region overlap (misconfiguration): SRAM takes precedence. An SVA asserts that the regions do not overlap.

## Structure
- Package ssb_pkg:
  - host index enum (HOST_DBG, HOST_INS, HOST_DAT);
  - device enum (DEV_NONE, DEV_SRAM, DEV_DMEM);
  - default region constants.
- One sub-module, ssb_rr_arb2: 2-requester round-robin with registered pointer, used for ins/dat.
- SVA: gnt one-hot-or-zero; rvalid one-hot-or-zero; rvalid(N+1) iff gnt(N).

## Test plan
- dat read at 0x0000_0100, SRAM returns 0xDEADBEEF: gnt cycle N, dat_rvalid=1 at N+1 with rdata=0xDEADBEEF and err=0. ins and dbg see no rvalid.
- ins and dat both requesting continuously for 6 cycles: grants alternate ins,dat,ins,dat,ins,dat. Each rvalid lands on the correct host one cycle later.
- dbg requesting continuously with dat pending, MaxDbgHold=8: dbg is granted 8 cycles, dat is granted on the 9th, then dbg resumes.
- dat write to 0x2000_0000 (unmapped): gnt=1, no sram/dmem strobe, next cycle dat_rvalid=1, err=1, rdata=0.
- ins fetch at 0x1A11_0800: dmem_req_o=1. dmem_rdata_i=0x0000_0013 returned as ins_rdata with err=0.
- Assert rst_sys_n low in the cycle after a dat grant: no rvalid is ever issued for it. All outputs read 0 during reset, and the RR pointer favours ins after release.
